// File: rtl/note_key_encoder_pkg.sv
// Shared note codes and key-to-note encoding helpers for the song recogniser.
package note_key_encoder_pkg;

    localparam int KEY_COUNT = 8;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    function automatic logic [3:0] key_code(input int idx);
        logic [3:0] code;
        code = NOTE_NONE;
        case (idx)
            0: code = NOTE_C4;
            1: code = NOTE_D;
            2: code = NOTE_E;
            3: code = NOTE_F;
            4: code = NOTE_G;
            5: code = NOTE_A;
            6: code = NOTE_B;
            7: code = NOTE_C5;
            default: code = NOTE_NONE;
        endcase
        return code;
    endfunction

    // Scan from the top so the lowest-index pressed key is written last.
    function automatic logic [3:0] priority_encode(input logic [KEY_COUNT-1:0] v);
        logic [3:0] code;
        code = NOTE_NONE;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (v[i]) code = key_code(i);
        end
        return code;
    endfunction

    function automatic logic is_chord(input logic [KEY_COUNT-1:0] v);
        return $countones(v) > 1;
    endfunction

endpackage

// File: rtl/note_key_encoder_key_debounce.sv
// One key: two-flop synchroniser followed by a stable-count debouncer.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic key,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/note_key_encoder.sv
// Debounced piano keys to registered note code; define
// NOTE_KEY_CHORD_REJECT_EN to encode multi-key chords as none.
module note_key_encoder
    import note_key_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_KEYS        = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [3:0]          note,
    output logic                note_change,
    output logic [NUM_KEYS-1:0] key_led
);

    logic [NUM_KEYS-1:0] db;
    logic [3:0]          next_note;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK  (CLK),
            .RESET(RESET),
            .key  (keys[k]),
            .db   (db[k])
        );
    end

    assign key_led = db;

    always_comb begin
        next_note = priority_encode(db);
`ifdef NOTE_KEY_CHORD_REJECT_EN
        if (is_chord(db)) next_note = NOTE_NONE;
`endif
    end

    // Pulse only when the visible code moves, not on every recompute.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            note        <= NOTE_NONE;
            note_change <= 1'b0;
        end else begin
            note        <= next_note;
            note_change <= (next_note != note);
        end
    end

endmodule

// File: tb/tb_note_key_encoder.sv
// Scoreboard bench for note_key_encoder with DEBOUNCE_CYCLES=4.
module tb_note_key_encoder;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    typedef struct {
        logic [3:0] note;
        int         cyc;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] keys = 8'hFF;
    logic [3:0] note;
    logic       note_change;
    logic [7:0] key_led;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    note_key_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_KEYS       (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .keys       (keys),
        .note       (note),
        .note_change(note_change),
        .key_led    (key_led)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the queue, on time.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (note_change === 1'b1) begin
                pulses++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: note %h at cycle %0d", note, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (note !== e.note || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL pulse: got note %h cycle %0d want note %h cycle %0d",
                                 note, cyc, e.note, e.cyc);
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                exp_t e;
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_pulse: note %h now %h want note %h by cycle %0d",
                         note, note, e.note, e.cyc);
            end
        end
    end

    task automatic drive(input logic [7:0] k);
        @(negedge CLK);
        keys = k;
    endtask

    task automatic expect_note(input logic [3:0] n);
        q.push_back('{note: n, cyc: cyc + LAT});
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        // Reset held with all keys down.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_note", {4'd0, note}, 8'h00);
            check("rst_chg", {7'd0, note_change}, 8'h00);
            check("rst_led", key_led, 8'h00);
        end
        RESET = 1'b0;
        mon_en = 1'b1;
        expect_note(4'd1);
        wait_n(LAT - 1);
        check("led_before_note", key_led, 8'hFF);
        check("note_lags_led", {4'd0, note}, 8'h00);
        wait_n(1);
        check("c4_after_reset", {4'd0, note}, 8'h01);
        wait_n(3);

        // Clear, then clean E press and release.
        drive(8'h00); expect_note(4'd0); wait_n(10);
        drive(8'h04); expect_note(4'd3); wait_n(10);
        check("e_held", {4'd0, note}, 8'h03);
        drive(8'h00); expect_note(4'd0); wait_n(10);

        // Bounce on E: only the final steady rise counts.
        drive(8'h04); wait_n(1);
        drive(8'h00); wait_n(1);
        drive(8'h04); wait_n(1);
        drive(8'h00); wait_n(1);
        drive(8'h04); expect_note(4'd3); wait_n(10);
        check("bounce_led", key_led, 8'h04);
        drive(8'h00); expect_note(4'd0); wait_n(10);

        // E+G together, then E released.
        drive(8'h14);
`ifndef NOTE_KEY_CHORD_REJECT_EN
        expect_note(4'd3);
`endif
        wait_n(10);
`ifdef NOTE_KEY_CHORD_REJECT_EN
        check("chord_note", {4'd0, note}, 8'h00);
`else
        check("chord_note", {4'd0, note}, 8'h03);
`endif
        drive(8'h10); expect_note(4'd5); wait_n(10);
        drive(8'h00); expect_note(4'd0); wait_n(10);

        // Reset while F is mid-debounce.
        drive(8'h08); wait_n(4);
        RESET = 1'b1;
        wait_n(2);
        check("midrst_led", key_led, 8'h00);
        check("midrst_note", {4'd0, note}, 8'h00);
        RESET = 1'b0;
        expect_note(4'd4);
        wait_n(LAT - 2);
        check("midrst_led_late", key_led, 8'h00);
        wait_n(8);
        check("f_after_rst", {4'd0, note}, 8'h04);

        // Note/none stepping for the recogniser.
        p0 = pulses;
        drive(8'h04); expect_note(4'd3); wait_n(10);
        drive(8'h00); expect_note(4'd0); wait_n(10);
        drive(8'h04); expect_note(4'd3); wait_n(10);
        drive(8'h00); expect_note(4'd0); wait_n(10);
        drive(8'h08); expect_note(4'd4); wait_n(10);
        check("seq_pulses", 8'(pulses - p0), 8'd5);
        check("seq_last", {4'd0, note}, 8'h04);

        wait_n(5);
        check("pending", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_key_encoder.md
Name: note_key_encoder

Overview:
- Upstream stage of the song-recognition FSMs.
- Takes 8 raw piano-key switches, synchronises and debounces each one, then encodes the pressed key into the shared 4-bit note code.
- Output `note` feeds the song recogniser's `note` input directly.
- Releasing all keys yields code `none`, which gives the recogniser the note/none alternation it steps on.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key change is accepted (5 ms at 100 MHz); legal range 2..2^20.
- NUM_KEYS, 8, number of key inputs; fixed at 8 for this revision.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- keys  input  8  raw asynchronous key switches; bit0=C4, bit1=D, bit2=E, bit3=F, bit4=G, bit5=A, bit6=B, bit7=C5
- note  output  4  encoded note code of the currently held key, or `none`
- note_change  output  1  one-cycle pulse when `note` takes a new value
- key_led  output  8  debounced key vector, for LED display

Behaviour:
- Clock and reset: one clock domain (CLK); RESET is synchronous and active-high. All state clears only on a CLK edge with RESET=1.
- Reset values:
  - note = none (4'd0); note_change = 0; key_led = 8'h00.
  - Sync flops = 0; all debounce counters = 0.
- Synchroniser: each key bit passes through 2 flops (sync1, sync2) before debounce.
- Debounce, per key, with state db and counter cnt:
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt width = clog2(DEBOUNCE_CYCLES).
  - Any bounce back to the db value restarts the count from 0.
- Encoding (combinational from db vector, then registered into `note`):
  - No key pressed: none.
  - Exactly one key pressed: its code.
  - More than one key pressed: lowest-index pressed key wins (see Optional Feature).
- note_change is registered: it is 1 for exactly one cycle, the cycle in which the new `note` value first appears.
- Latency: a raw edge held steady reaches `note` exactly DEBOUNCE_CYCLES+3 CLK edges after the first sampling edge. That is 2 sync cycles, DEBOUNCE_CYCLES cycles to accept the change, and 1 cycle for the output register.
- key_led = db vector, same timing as db (one cycle ahead of `note`).
- Boundary conditions:
  - Reset mid-debounce: all counters clear; the partial count is discarded.
  - Simultaneous press and release of different keys: each key debounces independently. `note` may pass through none or the other key's code, and each transition pulses note_change.
  - A debounced key vector that is unchanged produces no note_change, even when the encoded code is recomputed.
  - Counter saturation cannot occur: it always wraps to 0 on acceptance.

Optional Feature:
- Macro: NOTE_KEY_CHORD_REJECT_EN.
- Defined: if more than one debounced key is pressed, `note` = none, because chords are not notes.
- Undefined: lowest-index priority as above.
- Everything else is identical in both builds.

Decomposition:
- Shared package (the existing parameters include file) holds the note codes: none=4'd0, C4=4'd1, D=4'd2, E=4'd3, F=4'd4, G=4'd5, A=4'd6, B=4'd7, C5=4'd8. The recogniser FSMs use the same constants.
- Sub-module key_debounce: one key, containing the 2-flop sync, counter and db. It takes parameter DEBOUNCE_CYCLES and is instantiated NUM_KEYS times via generate.
- Top level contains the encoder, the output register and the change detector.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset: hold RESET 3 cycles with keys=8'hFF → note=0, note_change=0, key_led=0 throughout. After release, key_led=8'hFF and note=4'd1 (C4) at cycle 7, with a single note_change pulse.
- Clean E press: keys=8'h04 held → note=4'd3 exactly 7 edges after first sample, note_change high 1 cycle. Release → note=0 after 7 edges, 1 pulse.
- Bounce rejection: keys bit2 toggles 1,0,1,0 every 2 cycles, then held 1 → no change until 7 edges after the final rising edge; exactly one pulse.
- Two keys (default build): keys=8'h14 (E+G) → note=4'd3. Release E only → note=4'd5 with one pulse. Chord-reject build: 8'h14 → note=0, no pulse from 0.
- Reset mid-operation: press F, assert RESET at debounce count 2 → note stays 0. After RESET drops with F still held, note=4'd4 after 7 edges.
- Downstream sequence: drive E, release, E, release, F → note sequence 3,0,3,0,4 with 5 note_change pulses, matching the note/none stepping the recogniser expects.
